// File: rtl/avalon_bus_matrix_grant_ctrl.sv
// Grant holder downstream of the bus-matrix arbiter: latches a port grant and keeps it for one Avalon-MM transaction.
// Optional read-response watchdog enabled by defining AVALON_BM_GRANT_TIMEOUT_EN.
module avalon_bus_matrix_grant_ctrl #(
  parameter int unsigned BCW            = 4,
  parameter int unsigned NPORT          = 5,
  parameter int unsigned TIMEOUT_CYCLES = 1024
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [2:0]       arb_sel_i,
  input  logic             arb_nosel_i,
  input  logic             sel_read_i,
  input  logic             sel_write_i,
  input  logic [BCW-1:0]   sel_burstcount_i,
  input  logic             s_waitrequest_i,
  input  logic             s_readdatavalid_i,
  output logic [2:0]       grant_sel_o,
  output logic             grant_vld_o,
  output logic [NPORT-1:0] grant_onehot_o,
  output logic             busy_o,
  output logic             timeout_o
);

  typedef enum logic [1:0] {S_IDLE, S_GRANT, S_WR_BURST, S_RD_WAIT} state_t;

  state_t           r_state, w_state_nxt;
  logic [2:0]       r_sel, w_sel_nxt;
  logic             r_vld, w_vld_nxt;
  logic [NPORT-1:0] r_onehot;
  logic [BCW-1:0]   r_wr_rem, w_wr_rem_nxt;
  logic [BCW-1:0]   r_rd_rem, w_rd_rem_nxt;
  logic [BCW-1:0]   w_len, w_rd_left;
  logic             w_wr_acc, w_rd_acc, w_timeout_hit;

  // A burstcount of 0 is treated as a single beat.
  assign w_len     = (sel_burstcount_i == '0) ? BCW'(1) : sel_burstcount_i;
  assign w_rd_left = w_len - BCW'(s_readdatavalid_i);
  assign w_wr_acc  = sel_write_i & ~s_waitrequest_i & r_vld;
  assign w_rd_acc  = sel_read_i  & ~s_waitrequest_i & r_vld;

  always_comb begin
    w_state_nxt  = r_state;
    w_sel_nxt    = r_sel;
    w_vld_nxt    = r_vld;
    w_wr_rem_nxt = r_wr_rem;
    w_rd_rem_nxt = r_rd_rem;
    unique case (r_state)
      S_IDLE: begin
        if (~arb_nosel_i) begin
          w_sel_nxt   = (arb_sel_i >= 3'(NPORT)) ? '0 : arb_sel_i;
          w_vld_nxt   = 1'b1;
          w_state_nxt = S_GRANT;
        end
      end
      S_GRANT: begin
        // Write is checked first so it wins when both strobes are asserted.
        if (w_wr_acc) begin
          if (w_len == BCW'(1)) begin
            w_vld_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_wr_rem_nxt = w_len - BCW'(1);
            w_state_nxt  = S_WR_BURST;
          end
        end else if (w_rd_acc) begin
          if (w_rd_left == '0) begin
            w_vld_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end else begin
            w_rd_rem_nxt = w_rd_left;
            w_state_nxt  = S_RD_WAIT;
          end
        end else if (~sel_read_i & ~sel_write_i) begin
          w_vld_nxt   = 1'b0;
          w_state_nxt = S_IDLE;
        end
      end
      S_WR_BURST: begin
        if (sel_write_i & ~s_waitrequest_i & (r_wr_rem != '0)) begin
          w_wr_rem_nxt = r_wr_rem - BCW'(1);
          if (r_wr_rem == BCW'(1)) begin
            w_vld_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      S_RD_WAIT: begin
        if (w_timeout_hit) begin
          w_rd_rem_nxt = '0;
          w_vld_nxt    = 1'b0;
          w_state_nxt  = S_IDLE;
        end else if (s_readdatavalid_i & (r_rd_rem != '0)) begin
          w_rd_rem_nxt = r_rd_rem - BCW'(1);
          if (r_rd_rem == BCW'(1)) begin
            w_vld_nxt   = 1'b0;
            w_state_nxt = S_IDLE;
          end
        end
      end
      default: w_state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      r_state  <= S_IDLE;
      r_sel    <= '0;
      r_vld    <= 1'b0;
      r_onehot <= '0;
      r_wr_rem <= '0;
      r_rd_rem <= '0;
    end else begin
      r_state  <= w_state_nxt;
      r_sel    <= w_sel_nxt;
      r_vld    <= w_vld_nxt;
      r_onehot <= w_vld_nxt ? (NPORT'(1) << w_sel_nxt) : '0;
      r_wr_rem <= w_wr_rem_nxt;
      r_rd_rem <= w_rd_rem_nxt;
    end
  end

`ifdef AVALON_BM_GRANT_TIMEOUT_EN
  localparam int unsigned WDW = $clog2(TIMEOUT_CYCLES + 1);

  logic [WDW-1:0] r_wd;
  logic           r_timeout;

  // Fires on the TIMEOUT_CYCLES-th consecutive RD_WAIT cycle without a response beat.
  assign w_timeout_hit = (r_state == S_RD_WAIT) & ~s_readdatavalid_i &
                         (r_wd == WDW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk) begin
    if (rst) begin
      r_wd      <= '0;
      r_timeout <= 1'b0;
    end else begin
      r_timeout <= w_timeout_hit;
      if ((r_state != S_RD_WAIT) || s_readdatavalid_i || w_timeout_hit)
        r_wd <= '0;
      else
        r_wd <= r_wd + WDW'(1);
    end
  end

  assign timeout_o = r_timeout;
`else
  logic w_unused_timeout;
  assign w_unused_timeout = (TIMEOUT_CYCLES == 0);
  assign w_timeout_hit    = 1'b0;
  assign timeout_o        = 1'b0;
`endif

  assign grant_sel_o    = r_sel;
  assign grant_vld_o    = r_vld;
  assign grant_onehot_o = r_onehot;
  assign busy_o         = (r_state != S_IDLE);

endmodule

// File: tb/tb_avalon_bus_matrix_grant_ctrl.sv
// Scoreboard bench for avalon_bus_matrix_grant_ctrl: stimulus queues expected outputs per cycle, a monitor compares.
module tb_avalon_bus_matrix_grant_ctrl;

  logic       clk = 1'b0;
  logic       rst;
  logic [2:0] arb_sel;
  logic       arb_nosel, rd, wr, wreq, rdv;
  logic [3:0] bc;
  logic [2:0] grant_sel;
  logic       grant_vld, busy, tmo;
  logic [4:0] grant_onehot;

  always #5 clk = ~clk;

  avalon_bus_matrix_grant_ctrl #(
    .BCW(4),
    .NPORT(5),
    .TIMEOUT_CYCLES(16)
  ) dut (
    .clk(clk),
    .rst(rst),
    .arb_sel_i(arb_sel),
    .arb_nosel_i(arb_nosel),
    .sel_read_i(rd),
    .sel_write_i(wr),
    .sel_burstcount_i(bc),
    .s_waitrequest_i(wreq),
    .s_readdatavalid_i(rdv),
    .grant_sel_o(grant_sel),
    .grant_vld_o(grant_vld),
    .grant_onehot_o(grant_onehot),
    .busy_o(busy),
    .timeout_o(tmo)
  );

  typedef struct packed {
    logic [2:0] sel;
    logic       vld;
    logic [4:0] oh;
    logic       busy;
    logic       to;
  } obs_t;

  obs_t  exp_q[$];
  string name_q[$];
  int    checks = 0;
  int    errors = 0;

  // Advance one clock edge and queue the outputs expected after it.
  task automatic cyc(input string nm, input logic [2:0] s, input logic v,
                     input logic b, input logic t);
    obs_t e;
    logic [4:0] one;
    one    = 5'b00001;
    e.sel  = s;
    e.vld  = v;
    e.oh   = v ? (one << s) : 5'b00000;
    e.busy = b;
    e.to   = t;
    @(posedge clk);
    exp_q.push_back(e);
    name_q.push_back(nm);
    #1;
  endtask

  task automatic drv(input logic r, input logic w, input logic [3:0] c,
                     input logic wq, input logic dv);
    rd = r; wr = w; bc = c; wreq = wq; rdv = dv;
  endtask

  initial begin : monitor
    obs_t  e, a;
    string nm;
    forever begin
      @(negedge clk);
      if (exp_q.size() > 0) begin
        e  = exp_q.pop_front();
        nm = name_q.pop_front();
        a  = {grant_sel, grant_vld, grant_onehot, busy, tmo};
        checks++;
        if (a !== e) begin
          errors++;
          $display("FAIL %s: got sel=%0d vld=%b oh=%b busy=%b to=%b, expected sel=%0d vld=%b oh=%b busy=%b to=%b",
                   nm, a.sel, a.vld, a.oh, a.busy, a.to, e.sel, e.vld, e.oh, e.busy, e.to);
        end
      end
    end
  end

  initial begin : stim
    logic [9:0] rdv_pat;
    rst = 1'b1; arb_sel = 3'd2; arb_nosel = 1'b0;
    drv(0, 0, 4'd0, 0, 0);

    // Reset held 3 cycles with a pending request
    repeat (3) cyc("reset", 3'd0, 0, 0, 0);
    rst = 1'b0;
    cyc("first_grant", 3'd2, 1, 1, 0);
    arb_nosel = 1'b1;
    cyc("withdraw_release", 3'd2, 0, 0, 0);

    // Single write
    arb_sel = 3'd1; arb_nosel = 1'b0;
    cyc("wr1_grant", 3'd1, 1, 1, 0);
    arb_nosel = 1'b1; drv(0, 1, 4'd1, 0, 0);
    cyc("wr1_release", 3'd1, 0, 0, 0);
    drv(0, 0, 4'd0, 0, 0);
    cyc("wr1_idle", 3'd1, 0, 0, 0);

    // Write burst L=4, waitrequest on beat 2, gap before beat 4, port-0 request mid-burst
    arb_sel = 3'd3; arb_nosel = 1'b0;
    cyc("wb_grant", 3'd3, 1, 1, 0);
    arb_nosel = 1'b1; drv(0, 1, 4'd4, 0, 0);
    cyc("wb_beat1", 3'd3, 1, 1, 0);
    drv(0, 1, 4'd4, 1, 0);
    cyc("wb_wait", 3'd3, 1, 1, 0);
    arb_sel = 3'd0; arb_nosel = 1'b0;
    drv(0, 1, 4'd4, 0, 0);
    cyc("wb_beat2", 3'd3, 1, 1, 0);
    cyc("wb_beat3", 3'd3, 1, 1, 0);
    drv(0, 0, 4'd4, 0, 0);
    cyc("wb_gap", 3'd3, 1, 1, 0);
    drv(0, 1, 4'd4, 0, 0);
    cyc("wb_beat4_release", 3'd3, 0, 0, 0);
    drv(0, 0, 4'd0, 0, 0);
    cyc("wb_port0_regrant", 3'd0, 1, 1, 0);
    arb_nosel = 1'b1;
    cyc("wb_port0_release", 3'd0, 0, 0, 0);

    // Read and write together: write wins (L=2 write burst)
    arb_sel = 3'd2; arb_nosel = 1'b0;
    cyc("rw_grant", 3'd2, 1, 1, 0);
    arb_nosel = 1'b1; drv(1, 1, 4'd2, 0, 0);
    cyc("rw_write_taken", 3'd2, 1, 1, 0);
    drv(0, 1, 4'd2, 0, 0);
    cyc("rw_beat2_release", 3'd2, 0, 0, 0);
    drv(0, 0, 4'd0, 0, 0);

    // Read burst L=8: 5-cycle latency, 8 beats with 2 gaps
    arb_sel = 3'd4; arb_nosel = 1'b0;
    cyc("rd8_grant", 3'd4, 1, 1, 0);
    arb_nosel = 1'b1; drv(1, 0, 4'd8, 0, 0);
    cyc("rd8_cmd", 3'd4, 1, 1, 0);
    drv(0, 0, 4'd0, 0, 0);
    repeat (4) cyc("rd8_latency", 3'd4, 1, 1, 0);
    rdv_pat = 10'b1101110111;
    for (int i = 0; i < 9; i++) begin
      rdv = rdv_pat[i];
      cyc("rd8_beats", 3'd4, 1, 1, 0);
    end
    rdv = rdv_pat[9];
    cyc("rd8_release", 3'd4, 0, 0, 0);
    rdv = 1'b1;
    cyc("rd8_stray_rdv_idle", 3'd4, 0, 0, 0);
    rdv = 1'b0;

    // Read with burstcount 0 treated as one beat
    arb_sel = 3'd1; arb_nosel = 1'b0;
    cyc("rd0_grant", 3'd1, 1, 1, 0);
    arb_nosel = 1'b1; drv(1, 0, 4'd0, 0, 0);
    cyc("rd0_wait", 3'd1, 1, 1, 0);
    drv(0, 0, 4'd0, 0, 1);
    cyc("rd0_release", 3'd1, 0, 0, 0);
    rdv = 1'b0;

    // Out-of-range select maps to 0; read with data in the command cycle releases at once
    arb_sel = 3'd5; arb_nosel = 1'b0;
    cyc("sel5_maps_0", 3'd0, 1, 1, 0);
    arb_nosel = 1'b1; drv(1, 0, 4'd1, 0, 1);
    cyc("rd1_same_cycle_release", 3'd0, 0, 0, 0);
    drv(0, 0, 4'd0, 0, 0);

    // Reset mid-read with rd_rem=5
    arb_sel = 3'd2; arb_nosel = 1'b0;
    cyc("rst_rd_grant", 3'd2, 1, 1, 0);
    arb_nosel = 1'b1; drv(1, 0, 4'd8, 0, 0);
    cyc("rst_rd_cmd", 3'd2, 1, 1, 0);
    drv(0, 0, 4'd0, 0, 1);
    repeat (3) cyc("rst_rd_beats", 3'd2, 1, 1, 0);
    rdv = 1'b0; rst = 1'b1;
    cyc("rst_mid_read", 3'd0, 0, 0, 0);
    rst = 1'b0; rdv = 1'b1;
    repeat (2) cyc("rst_stray_rdv", 3'd0, 0, 0, 0);
    rdv = 1'b0;

    // Read of L=2 with only one response beat
    arb_sel = 3'd3; arb_nosel = 1'b0;
    cyc("to_grant", 3'd3, 1, 1, 0);
    arb_nosel = 1'b1; drv(1, 0, 4'd2, 0, 0);
    cyc("to_cmd", 3'd3, 1, 1, 0);
    drv(0, 0, 4'd0, 0, 1);
    cyc("to_last_rdv", 3'd3, 1, 1, 0);
    rdv = 1'b0;
    repeat (15) cyc("to_holding", 3'd3, 1, 1, 0);
`ifdef AVALON_BM_GRANT_TIMEOUT_EN
    cyc("to_pulse_release", 3'd3, 0, 0, 1);
    cyc("to_pulse_end", 3'd3, 0, 0, 0);
`else
    repeat (4) cyc("to_disabled_hold", 3'd3, 1, 1, 0);
    rst = 1'b1;
    cyc("to_disabled_reset", 3'd0, 0, 0, 0);
    rst = 1'b0;
`endif

    // Drain the scoreboard within a bounded number of cycles
    for (int i = 0; i < 10 && exp_q.size() > 0; i++) @(negedge clk);
    @(negedge clk);
    #1;
    checks++;
    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL drain: got %0d pending entries, expected 0", exp_q.size());
    end
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
